// File: rtl/serial_bus_arbiter_n_pkg.sv
// serial_bus_arbiter_n_pkg: FSM states, arbitration modes and width helpers for the serial bus arbiter
package serial_bus_arbiter_n_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, SEL, CONNECTED, SPLIT, RESUME, CLEAN} state_t;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  function automatic int owner_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int sel_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_bus_arbiter_n_if.sv
// serial_bus_arbiter_n_if: master-side and slave-side bit-serial bus signals; slave modport is the arbiter view
interface serial_bus_arbiter_n_if #(
  parameter int NM = 2,
  parameter int NS = 4
);
  logic [NM-1:0] m_breq, m_bgrant, m_mode, m_wr, m_mvalid, m_mready;
  logic [NM-1:0] m_rd, m_ack, m_sready, m_svalid, m_split;
  logic [NS-1:0] s_mode, s_wr, s_mvalid, s_mready, s_rd, s_sready, s_svalid, s_split;
  modport slave (
    input m_breq, m_mode, m_wr, m_mvalid, m_mready, s_rd, s_sready, s_svalid, s_split,
    output m_bgrant, m_rd, m_ack, m_sready, m_svalid, m_split, s_mode, s_wr, s_mvalid, s_mready
  );
  modport master (
    output m_breq, m_mode, m_wr, m_mvalid, m_mready, s_rd, s_sready, s_svalid, s_split,
    input m_bgrant, m_rd, m_ack, m_sready, m_svalid, m_split, s_mode, s_wr, s_mvalid, s_mready
  );
endinterface

// File: rtl/serial_bus_arbiter_n_grant_sel.sv
// sba_grant_sel: combinational winner among unmasked requests, fixed priority or round-robin after last
module sba_grant_sel
  import serial_bus_arbiter_n_pkg::*;
#(
  parameter int NM = 2,
  parameter int MODE = ARB_FIXED
) (
  input  logic [NM-1:0]            req,
  input  logic [NM-1:0]            mask,
  input  logic [owner_w(NM)-1:0]   last,
  output logic                     any,
  output logic [owner_w(NM)-1:0]   win
);
  localparam int OW = owner_w(NM);
  logic [OW-1:0] c;
  // scan from lowest to highest priority slot so the best hit is written last
  always_comb begin
    any = 1'b0;
    win = '0;
    c = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      c = MODE == ARB_RR ? OW'((int'(last) + 1 + k) % NM) : OW'(k);
      if (req[c] && !mask[c]) begin
        any = 1'b1;
        win = c;
      end
    end
  end
endmodule

// File: rtl/serial_bus_arbiter_n.sv
// serial_bus_arbiter_n: bit-serial multi-master bus arbiter with split/resume; SBA_TIMEOUT_EN adds a watchdog and timeout_o
module serial_bus_arbiter_n
  import serial_bus_arbiter_n_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W = 2,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rstn,
  serial_bus_arbiter_n_if.slave           io,
  output logic                            busy,
  output logic [owner_w(NUM_MASTERS)-1:0] owner
`ifdef SBA_TIMEOUT_EN
  ,
  output logic                            timeout_o
`endif
);
  localparam int OW = owner_w(NUM_MASTERS);
  localparam int BW = sel_w(SEL_W + 1);
  localparam logic [SEL_W:0] NSL = (SEL_W + 1)'(NUM_SLAVES);
  localparam logic [BW-1:0] LASTBIT = BW'(SEL_W - 1);
  state_t state, state_nxt;
  logic [OW-1:0] owner_nxt, last_owner, last_nxt, w_win, r_win;
  logic [SEL_W-1:0] sel, sel_nxt, sh;
  logic [BW-1:0] nbit, nbit_nxt;
  logic [NUM_MASTERS-1:0] parked, parked_nxt, resumable;
  logic [NUM_MASTERS-1:0][SEL_W-1:0] psel, psel_nxt;
  logic w_any, r_any, tmo_hit;
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    assign resumable[i] = parked[i] & ~io.s_split[psel[i]];
    assign io.m_split[i] = parked[i] & io.s_split[psel[i]];
  end
  sba_grant_sel #(.NM(NUM_MASTERS), .MODE(ARB_MODE)) u_arb (
    .req(io.m_breq), .mask(parked), .last(last_owner), .any(w_any), .win(w_win)
  );
  sba_grant_sel #(.NM(NUM_MASTERS), .MODE(ARB_FIXED)) u_res (
    .req(resumable), .mask('0), .last('0), .any(r_any), .win(r_win)
  );
  assign busy = state != IDLE;
`ifdef SBA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  logic watch, act;
  assign watch = state == SEL || state == CONNECTED;
  assign act = io.m_mvalid[owner] | (state == CONNECTED & io.s_svalid[sel]);
  assign tmo_hit = watch & ~act & (tcnt == TLIM);
  // count silent cycles during address and data phases, pulse when the limit is hit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      tcnt <= watch & ~act ? tcnt + 1'b1 : '0;
      timeout_o <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif
  // state, ownership, address shifter and split table registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      owner <= '0;
      last_owner <= OW'(NUM_MASTERS - 1);
      sel <= '0;
      nbit <= '0;
      parked <= '0;
      psel <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last_owner <= last_nxt;
      sel <= sel_nxt;
      nbit <= nbit_nxt;
      parked <= parked_nxt;
      psel <= psel_nxt;
    end
  end
  // next state: resumes beat new requests, address bits shift MSB first, splits park the owner
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt = last_owner;
    sel_nxt = sel;
    nbit_nxt = nbit;
    parked_nxt = parked;
    psel_nxt = psel;
    sh = SEL_W'({sel, io.m_wr[owner]});
    case (state)
      IDLE:
        if (r_any) begin
          state_nxt = RESUME;
          owner_nxt = r_win;
          sel_nxt = psel[r_win];
          parked_nxt[r_win] = 1'b0;
        end else if (w_any) begin
          state_nxt = GRANT;
          owner_nxt = w_win;
        end
      GRANT: begin
        sel_nxt = '0;
        nbit_nxt = '0;
        state_nxt = io.m_breq[owner] ? SEL : CLEAN;
      end
      SEL:
        if (!io.m_breq[owner] || tmo_hit) state_nxt = CLEAN;
        else if (io.m_mvalid[owner]) begin
          sel_nxt = sh;
          nbit_nxt = nbit + 1'b1;
          if (nbit == LASTBIT) state_nxt = {1'b0, sh} < NSL ? CONNECTED : CLEAN;
        end
      CONNECTED:
        if (!io.m_breq[owner] || tmo_hit) state_nxt = CLEAN;
        else if (io.s_split[sel]) begin
          state_nxt = SPLIT;
          parked_nxt[owner] = 1'b1;
          psel_nxt[owner] = sel;
        end
      SPLIT: state_nxt = IDLE;
      RESUME: state_nxt = CONNECTED;
      CLEAN: begin
        last_nxt = owner;
        sel_nxt = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // owner handshake and slave routing; everything zero for non-owners and unselected slaves
  always_comb begin
    io.m_bgrant = '0;
    io.m_ack = '0;
    io.m_rd = '0;
    io.m_sready = '0;
    io.m_svalid = '0;
    io.s_mode = '0;
    io.s_wr = '0;
    io.s_mvalid = '0;
    io.s_mready = '0;
    io.m_bgrant[owner] = state inside {SEL, CONNECTED, RESUME};
    io.m_ack[owner] = state inside {CONNECTED, RESUME};
    io.m_sready[owner] = state == SEL;
    if (state == CONNECTED) begin
      io.s_mode[sel] = io.m_mode[owner];
      io.s_wr[sel] = io.m_wr[owner];
      io.s_mvalid[sel] = io.m_mvalid[owner];
      io.s_mready[sel] = io.m_mready[owner];
      io.m_rd[owner] = io.s_rd[sel];
      io.m_sready[owner] = io.s_sready[sel];
      io.m_svalid[owner] = io.s_svalid[sel];
    end
  end
endmodule

// File: tb/tb_serial_bus_arbiter_n.sv
// tb_serial_bus_arbiter_n: random traffic into a fixed-priority and a round-robin arbiter, checked against a transaction-phase model
module tb_serial_bus_arbiter_n;
  import serial_bus_arbiter_n_pkg::*;
  localparam int NM = 3, NS = 3, SW = 2, TO = 8;
`ifdef SBA_TIMEOUT_EN
  localparam bit TOEN = 1'b1;
`else
  localparam bit TOEN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_GNT = 1, P_SEL = 2, P_CONN = 3, P_SPLIT = 4, P_RES = 5, P_CLN = 6;
  logic clk = 1'b0, rstn = 1'b0;
  logic [NM-1:0] breq, mode, wr, mvalid, mready;
  logic [NS-1:0] srd, sready, svalid, ssplit;
  logic busy0, busy1, to0, to1;
  logic [1:0] own0, own1;
  int n_cmp = 0, n_bad = 0;
  int ph[2], own[2], last[2], sl[2], nb[2], tc[2];
  bit tout[2];
  bit pk[2][NM];
  int ps[2][NM];
  serial_bus_arbiter_n_if #(.NM(NM), .NS(NS)) if0 ();
  serial_bus_arbiter_n_if #(.NM(NM), .NS(NS)) if1 ();
  always #5 clk = ~clk;
  assign if0.m_breq = breq;
  assign if0.m_mode = mode;
  assign if0.m_wr = wr;
  assign if0.m_mvalid = mvalid;
  assign if0.m_mready = mready;
  assign if0.s_rd = srd;
  assign if0.s_sready = sready;
  assign if0.s_svalid = svalid;
  assign if0.s_split = ssplit;
  assign if1.m_breq = breq;
  assign if1.m_mode = mode;
  assign if1.m_wr = wr;
  assign if1.m_mvalid = mvalid;
  assign if1.m_mready = mready;
  assign if1.s_rd = srd;
  assign if1.s_sready = sready;
  assign if1.s_svalid = svalid;
  assign if1.s_split = ssplit;
`ifndef SBA_TIMEOUT_EN
  assign to0 = 1'b0;
  assign to1 = 1'b0;
`endif
  serial_bus_arbiter_n #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SEL_W(SW), .ARB_MODE(ARB_FIXED), .TIMEOUT(TO)) u0 (
    .clk(clk), .rstn(rstn), .io(if0), .busy(busy0), .owner(own0)
`ifdef SBA_TIMEOUT_EN
    , .timeout_o(to0)
`endif
  );
  serial_bus_arbiter_n #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SEL_W(SW), .ARB_MODE(ARB_RR), .TIMEOUT(TO)) u1 (
    .clk(clk), .rstn(rstn), .io(if1), .busy(busy1), .owner(own1)
`ifdef SBA_TIMEOUT_EN
    , .timeout_o(to1)
`endif
  );
  function automatic logic [39:0] pack(logic t, logic b, logic [1:0] o, logic [NM-1:0] g, logic [NM-1:0] rd,
                                       logic [NM-1:0] a, logic [NM-1:0] sr, logic [NM-1:0] sv, logic [NM-1:0] sp,
                                       logic [NS-1:0] sm, logic [NS-1:0] sw, logic [NS-1:0] smv, logic [NS-1:0] smr);
    return 40'({t, b, o, g, rd, a, sr, sv, sp, sm, sw, smv, smr});
  endfunction
  function automatic logic [39:0] expect_out(int k);
    logic [NM-1:0] g = '0, rd = '0, a = '0, sr = '0, sv = '0, sp = '0;
    logic [NS-1:0] sm = '0, sw = '0, smv = '0, smr = '0;
    int o = own[k];
    int s = sl[k];
    if (ph[k] == P_SEL || ph[k] == P_CONN || ph[k] == P_RES) g[o] = 1'b1;
    if (ph[k] == P_CONN || ph[k] == P_RES) a[o] = 1'b1;
    if (ph[k] == P_SEL) sr[o] = 1'b1;
    if (ph[k] == P_CONN) begin
      sm[s] = mode[o];
      sw[s] = wr[o];
      smv[s] = mvalid[o];
      smr[s] = mready[o];
      rd[o] = srd[s];
      sr[o] = sready[s];
      sv[o] = svalid[s];
    end
    for (int i = 0; i < NM; i++) sp[i] = pk[k][i] && ssplit[ps[k][i]];
    return pack(tout[k], ph[k] != P_IDLE, 2'(o), g, rd, a, sr, sv, sp, sm, sw, smv, smr);
  endfunction
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, "_fixed"}, pack(to0, busy0, own0, if0.m_bgrant, if0.m_rd, if0.m_ack, if0.m_sready, if0.m_svalid,
          if0.m_split, if0.s_mode, if0.s_wr, if0.s_mvalid, if0.s_mready), expect_out(0));
    check({tag, "_rr"}, pack(to1, busy1, own1, if1.m_bgrant, if1.m_rd, if1.m_ack, if1.m_sready, if1.m_svalid,
          if1.m_split, if1.s_mode, if1.s_wr, if1.s_mvalid, if1.s_mready), expect_out(1));
  endtask
  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_IDLE;
      own[k] = 0;
      last[k] = NM - 1;
      sl[k] = 0;
      nb[k] = 0;
      tc[k] = 0;
      tout[k] = 1'b0;
      for (int i = 0; i < NM; i++) begin
        pk[k][i] = 1'b0;
        ps[k][i] = 0;
      end
    end
  endtask
  task automatic mstep(input int k, input int amode);
    bit act, hit, watch;
    int r, w, c, o;
    o = own[k];
    watch = ph[k] == P_SEL || ph[k] == P_CONN;
    act = mvalid[o] || (ph[k] == P_CONN && svalid[sl[k]]);
    hit = TOEN && watch && !act && tc[k] == TO - 1;
    tout[k] = hit;
    tc[k] = watch && !act ? tc[k] + 1 : 0;
    case (ph[k])
      P_IDLE: begin
        r = -1;
        w = -1;
        for (int i = 0; i < NM; i++) if (r < 0 && pk[k][i] && !ssplit[ps[k][i]]) r = i;
        for (int j = 0; j < NM; j++) begin
          c = amode == ARB_RR ? (last[k] + 1 + j) % NM : j;
          if (w < 0 && breq[c] && !pk[k][c]) w = c;
        end
        if (r >= 0) begin
          own[k] = r;
          sl[k] = ps[k][r];
          pk[k][r] = 1'b0;
          ph[k] = P_RES;
        end else if (w >= 0) begin
          own[k] = w;
          ph[k] = P_GNT;
        end
      end
      P_GNT: begin
        sl[k] = 0;
        nb[k] = 0;
        ph[k] = breq[o] ? P_SEL : P_CLN;
      end
      P_SEL:
        if (!breq[o] || hit) ph[k] = P_CLN;
        else if (mvalid[o]) begin
          sl[k] = (sl[k] * 2 + int'(wr[o])) % (1 << SW);
          nb[k]++;
          if (nb[k] == SW) ph[k] = sl[k] < NS ? P_CONN : P_CLN;
        end
      P_CONN:
        if (!breq[o] || hit) ph[k] = P_CLN;
        else if (ssplit[sl[k]]) begin
          pk[k][o] = 1'b1;
          ps[k][o] = sl[k];
          ph[k] = P_SPLIT;
        end
      P_SPLIT: ph[k] = P_IDLE;
      P_RES: ph[k] = P_CONN;
      P_CLN: begin
        last[k] = o;
        sl[k] = 0;
        ph[k] = P_IDLE;
      end
      default: ph[k] = P_IDLE;
    endcase
  endtask
  initial begin
    {breq, mode, wr, mvalid, mready} = '0;
    {srd, sready, svalid, ssplit} = '0;
    mreset();
    #1;
    check_all("reset");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NM; i++) if ($urandom_range(15) == 0) breq[i] = ~breq[i];
      for (int i = 0; i < NS; i++) if ($urandom_range(23) == 0) ssplit[i] = ~ssplit[i];
      {mode, wr, mvalid, mready} = 12'($urandom);
      {srd, sready, svalid} = 9'($urandom);
      if ($urandom_range(399) == 0) begin
        rstn = 1'b0;
        mreset();
        #1;
        check_all("async_reset");
      end else rstn = 1'b1;
      @(negedge clk);
      check_all($sformatf("cyc%0d", cyc));
      @(posedge clk);
      if (!rstn) mreset();
      else begin
        mstep(0, ARB_FIXED);
        mstep(1, ARB_RR);
      end
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
